cardio_feature_loader: RTL and testbench
========================================

CARDIO_FEATURE_LOADER -- requirements
Module: cardio_feature_loader

Interface
REQ-001 SHALL have parameter N_FEAT, default 21: features per frame.
REQ-002 SHALL have parameter IN_W, default 8: raw sample width, unsigned.
REQ-003 SHALL have parameter Q_W, default 4: quantized feature width, unsigned.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: raw sample valid.
REQ-007 SHALL have port s_data, input, IN_W bits: raw sample.
REQ-008 SHALL have port s_last, input, 1 bit: marks the final sample of a frame.
REQ-009 SHALL have port s_ready, output, 1 bit: loader accepts a sample.
REQ-010 SHALL have port m_feat, output, N_FEAT*Q_W bits: packed feature vector for the regressor input bus; feature i at bits [Q_W*i+Q_W-1 : Q_W*i].
REQ-011 SHALL have port m_valid, output, 1 bit: m_feat holds a complete frame.
REQ-012 SHALL have port m_ready, input, 1 bit: consumer accepts the frame.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a discarded frame.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of discarded frames.

Function
REQ-015 Sample accepted only in a cycle where s_valid=1 and s_ready=1; output frame transfers only where m_valid=1 and m_ready=1.
REQ-016 Quantization: q = (s_data + 2^(IN_W-Q_W-1)) >> (IN_W-Q_W), computed IN_W+1 bits wide, saturated to 2^Q_W-1; defaults: 0..7->0, 8..23->1, 232..255->15.
REQ-017 Accepted sample k (k = 0..N_FEAT-1, 5-bit counter) writes its q into slot k of the collect buffer.
REQ-018 FSM states: COLLECT (s_ready=1) and PEND (s_ready=0).
REQ-019 COLLECT, accept with k<N_FEAT-1 and s_last=0: k increments.
REQ-020 COLLECT, accept with s_last=1 and k<N_FEAT-1: frame discarded, k<=0, frame_err pulses next cycle, stay COLLECT.
REQ-021 COLLECT, accept with k=N_FEAT-1 and s_last=0: sample dropped, frame discarded, k<=0, frame_err pulses next cycle.
REQ-022 COLLECT, accept with k=N_FEAT-1 and s_last=1: frame complete, k<=0; if output register free (m_valid=0, or m_valid=1 and m_ready=1 this cycle) copy buffer to m_feat and m_valid=1 next cycle (latency 1 cycle from last sample); otherwise go to PEND.
REQ-023 PEND: when output register frees, copy buffer to m_feat, keep m_valid=1, return to COLLECT next cycle; back-to-back frames produce no m_valid bubble.
REQ-024 m_feat and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-025 m_valid clears the cycle after a transfer unless a new frame is loaded in the same cycle.
REQ-026 err_cnt increments by 1 per frame_err pulse, saturating at 255.

Reset
REQ-027 While rst_n=0 at a rising edge: state=COLLECT, k=0, m_valid=0, m_feat=0, frame_err=0, err_cnt=0, collect buffer=0.
REQ-028 Reset mid-frame or in PEND SHALL drop all partial and pending data with no frame_err pulse; s_ready=1 the first cycle after reset release.

Structure
REQ-029 Shared package SHALL hold N_FEAT, IN_W, Q_W defaults, derived FEAT_BUS_W=N_FEAT*Q_W, counter width, and the state enum.
REQ-030 Quantizer SHALL be one combinational sub-module, cardio_feat_quant (IN_W, Q_W parameters).

Verification
REQ-031 21 samples of value 0x80, s_last on the 21st, m_ready=1 -> m_valid=1 one cycle after the last sample; every nibble of m_feat = 8.
REQ-032 Samples 0x00, 0x07, 0x08, 0x17, 0x18, 0xE8, 0xFF in slots 0..6 -> nibbles 0, 0, 1, 1, 2, 15, 15.
REQ-033 s_last asserted on the 10th sample -> frame_err pulse, err_cnt=1, no m_valid; next well-formed frame delivered correctly.
REQ-034 m_ready=0, two complete frames sent -> first frame held stable, loader enters PEND with s_ready=0; m_ready raised -> second frame appears the cycle after the first transfers, with no bubble.
REQ-035 rst_n=0 asserted after 12 samples -> outputs at reset values; a following 21-sample frame delivered with no frame_err.
REQ-036 256 malformed frames -> err_cnt saturates at 255.

Source files
------------

// File: rtl/cardio_feature_loader_pkg.sv
// rtl/cardio_feature_loader_pkg.sv - shared parameters and state type for the feature loader
package cardio_feature_loader_pkg;

    localparam int N_FEAT_DEF = 21;
    localparam int IN_W_DEF   = 8;
    localparam int Q_W_DEF    = 4;
    localparam int FEAT_BUS_W = N_FEAT_DEF * Q_W_DEF;
    localparam int CNT_W      = 5;

    typedef enum logic {
        COLLECT = 1'b0,
        PEND    = 1'b1
    } state_t;

endpackage

// File: rtl/cardio_feat_quant.sv
// rtl/cardio_feat_quant.sv - round-to-nearest quantizer with saturation to Q_W bits
module cardio_feat_quant #(
    parameter int IN_W = 8,
    parameter int Q_W  = 4
) (
    input  logic [IN_W-1:0] data,
    output logic [Q_W-1:0]  q
);

    localparam int SH   = IN_W - Q_W;
    localparam int QMAX = (1 << Q_W) - 1;
    // Half an output LSB; zero when no bits are dropped.
    localparam logic [IN_W:0] HALF = (SH > 0) ? ((IN_W+1)'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;

    logic [IN_W:0] sum;
    logic [IN_W:0] shifted;

    assign sum     = {1'b0, data} + HALF;
    assign shifted = sum >> SH;
    assign q       = (shifted > (IN_W+1)'(QMAX)) ? Q_W'(QMAX) : shifted[Q_W-1:0];

endmodule

// File: rtl/cardio_feature_loader.sv
// rtl/cardio_feature_loader.sv - collects quantized samples into frames and hands them to the regressor bus
module cardio_feature_loader
    import cardio_feature_loader_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int Q_W    = Q_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [N_FEAT*Q_W-1:0] m_feat,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  frame_err,
    output logic [7:0]            err_cnt
);

    localparam int                BUS_W  = N_FEAT * Q_W;
    localparam logic [CNT_W-1:0]  LAST_K = CNT_W'(N_FEAT - 1);

    state_t           state;
    logic [CNT_W-1:0] k;
    logic [BUS_W-1:0] buf_q;
    logic [BUS_W-1:0] buf_next;
    logic [Q_W-1:0]   q;
    logic             accept;
    logic             out_free;

    cardio_feat_quant #(.IN_W(IN_W), .Q_W(Q_W)) u_quant (
        .data (s_data),
        .q    (q)
    );

    assign s_ready  = (state == COLLECT);
    assign accept   = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;

    // Include the sample of this cycle so a completing frame can load m_feat directly.
    always_comb begin
        buf_next = buf_q;
        if (accept) begin
            buf_next[int'(k)*Q_W +: Q_W] = q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            k         <= '0;
            buf_q     <= '0;
            m_feat    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            frame_err <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                COLLECT: begin
                    if (accept) begin
                        buf_q <= buf_next;
                        if (k == LAST_K && s_last) begin
                            k <= '0;
                            if (out_free) begin
                                m_feat  <= buf_next;
                                m_valid <= 1'b1;
                            end else begin
                                state <= PEND;
                            end
                        end else if (s_last || k == LAST_K) begin
                            k         <= '0;
                            frame_err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            k <= k + CNT_W'(1);
                        end
                    end
                end
                PEND: begin
                    if (out_free) begin
                        m_feat  <= buf_q;
                        m_valid <= 1'b1;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cardio_feature_loader.sv
// tb/tb_cardio_feature_loader.sv - directed self-checking bench for cardio_feature_loader
module tb_cardio_feature_loader;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic [83:0] m_feat;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    cardio_feature_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_feat    (m_feat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d);
        for (int i = 0; i < 21; i++) send(d, i == 20);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (m_feat !== 84'h0) begin errors++; $display("FAIL reset_m_feat got %h want 0", m_feat); end
        checks++; if (frame_err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0b/%0d want 0/0", frame_err, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
    endtask

    task automatic test_basic;
        m_ready = 1'b1;
        send_frame(8'h80);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_m_valid got %0b want 1", m_valid); end
        checks++; if (m_feat !== {21{4'h8}}) begin errors++; $display("FAIL basic_m_feat got %h want %h", m_feat, {21{4'h8}}); end
        idle(1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_clear got %0b want 0", m_valid); end
    endtask

    task automatic test_quant;
        logic [7:0] vals [7];
        vals = '{8'h00, 8'h07, 8'h08, 8'h17, 8'h18, 8'hE8, 8'hFF};
        for (int i = 0; i < 21; i++) send((i < 7) ? vals[i] : 8'h00, i == 20);
        checks++; if (m_feat !== 84'h0FF21100) begin errors++; $display("FAIL quant_m_feat got %h want %h", m_feat, 84'h0FF21100); end
        idle(1);
    endtask

    task automatic test_short_frame;
        for (int i = 0; i < 10; i++) send(8'h44, i == 9);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err got %0b want 1", frame_err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL short_err_cnt got %0d want 1", err_cnt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL short_m_valid got %0b want 0", m_valid); end
        idle(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %0b want 0", frame_err); end
        send_frame(8'h30);
        checks++; if (m_valid !== 1'b1 || m_feat !== {21{4'h3}}) begin errors++; $display("FAIL short_next_frame got %0b/%h want 1/%h", m_valid, m_feat, {21{4'h3}}); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        m_ready = 1'b0;
        send_frame(8'h10);
        send_frame(8'h50);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend_s_ready got %0b want 0", s_ready); end
        idle(3);
        checks++; if (m_valid !== 1'b1 || m_feat !== {21{4'h1}}) begin errors++; $display("FAIL b2b_hold got %0b/%h want 1/%h", m_valid, m_feat, {21{4'h1}}); end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1 || m_feat !== {21{4'h5}}) begin errors++; $display("FAIL b2b_second got %0b/%h want 1/%h", m_valid, m_feat, {21{4'h5}}); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_resume got %0b want 1", s_ready); end
        idle(1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", m_valid); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 12; i++) send(8'h40, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0 || m_feat !== 84'h0 || err_cnt !== 8'd0) begin errors++; $display("FAIL midreset_state got %0b/%h/%0d want 0/0/0", m_valid, m_feat, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h60);
        checks++; if (m_valid !== 1'b1 || m_feat !== {21{4'h6}}) begin errors++; $display("FAIL midreset_frame got %0b/%h want 1/%h", m_valid, m_feat, {21{4'h6}}); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midreset_err_cnt got %0d want 0", err_cnt); end
        idle(1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 21; i++) send(8'h22, 1'b0);
        checks++; if (frame_err !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL overrun got %0b/%0d want 1/1", frame_err, err_cnt); end
        for (int i = 0; i < 254; i++) send(8'h22, 1'b1);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", err_cnt); end
        send(8'h22, 1'b1);
        checks++; if (err_cnt !== 8'd255 || frame_err !== 1'b1) begin errors++; $display("FAIL sat_hold got %0d/%0b want 255/1", err_cnt, frame_err); end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset;
        test_basic;
        test_quant;
        test_short_frame;
        test_back_to_back;
        test_reset_mid;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
